fp_mul_pipe: RTL and testbench



---
 rtl/fp_mul_pipe.sv | 188 ++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - four-stage pipelined floating-point multiplier with round-to-nearest-even and valid/ready handshake
// Define FPMUL_SPECIAL_EN to decode Inf/NaN; without it every exponent is finite and overflow saturates.
module fp_mul_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   data1,
  input  logic [EXP_W+MAN_W:0]   data2,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   datanew,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             out_flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int P  = MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS = {3'b000, {(EXP_W-1){1'b1}}};
  localparam logic [EW-1:0] EMAX = {2'b00, {EXP_W{1'b1}}};
  localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

`ifdef FPMUL_SPECIAL_EN
  localparam bit SPECIAL = 1'b1;
`else
  localparam bit SPECIAL = 1'b0;
`endif

  logic en1, en2, en3, en4;

  // S1 unpack; class bits are {invalid, nan, inf, zero}
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, inv_c;
  logic [3:0]       cls_c;
  logic [2*P-1:0]   sig_a, sig_b;

  assign ea     = data1[W-2:MAN_W];
  assign eb     = data2[W-2:MAN_W];
  assign ma     = data1[MAN_W-1:0];
  assign mb     = data2[MAN_W-1:0];
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign inf_a  = SPECIAL && (&ea) && (ma == '0);
  assign inf_b  = SPECIAL && (&eb) && (mb == '0);
  assign nan_a  = SPECIAL && (&ea) && (ma != '0);
  assign nan_b  = SPECIAL && (&eb) && (mb != '0);
  assign inv_c  = (inf_a && zero_b) || (zero_a && inf_b);
  assign cls_c  = {inv_c, nan_a || nan_b || inv_c, inf_a || inf_b, zero_a || zero_b};
  assign sig_a  = {{P{1'b0}}, 1'b1, ma};
  assign sig_b  = {{P{1'b0}}, 1'b1, mb};

  logic             v1, sign1;
  logic [3:0]       cls1;
  logic [EW-1:0]    exp1;
  logic [2*P-1:0]   prod1;
  logic [TAG_W-1:0] tag1;

  // S2 normalise from the S1 product
  logic           norm_hi, guard_c, sticky_c;
  logic [P-1:0]   kept_c;
  logic [EW-1:0]  exp_n;

  assign norm_hi  = prod1[2*P-1];
  assign kept_c   = norm_hi ? prod1[2*P-1:P] : prod1[2*P-2:P-1];
  assign guard_c  = norm_hi ? prod1[P-1] : prod1[P-2];
  assign sticky_c = norm_hi ? (|prod1[P-2:0]) : (|prod1[P-3:0]);
  assign exp_n    = exp1 + {{(EW-1){1'b0}}, norm_hi};

  logic             v2, sign2, guard2, sticky2;
  logic [3:0]       cls2;
  logic [EW-1:0]    exp2;
  logic [P-1:0]     kept2;
  logic [TAG_W-1:0] tag2;

  // S3 round to nearest even
  logic         rnd_up;
  logic [P:0]   sum_c;

  assign rnd_up = guard2 && (kept2[0] || sticky2);
  assign sum_c  = {1'b0, kept2} + {{P{1'b0}}, rnd_up};

  logic             v3, sign3, inexact3;
  logic [3:0]       cls3;
  logic [EW-1:0]    exp3;
  logic [P:0]       sum3;
  logic [TAG_W-1:0] tag3;

  // S4 finalise: rounding carry, range checks and special results
  logic             carry;
  logic [MAN_W-1:0] man_f;
  logic [EW-1:0]    exp_f;
  logic [W-1:0]     res_c;
  logic [3:0]       flg_c;

  assign carry = sum3[P];
  assign man_f = carry ? sum3[MAN_W:1] : sum3[MAN_W-1:0];
  assign exp_f = exp3 + {{(EW-1){1'b0}}, carry};

  always_comb begin
    res_c = {sign3, exp_f[EXP_W-1:0], man_f};
    flg_c = {3'b000, inexact3};
    if (cls3[2]) begin
      res_c = QNAN;
      flg_c = {cls3[3], 3'b000};
    end else if (cls3[1]) begin
      res_c = {sign3, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg_c = 4'b0000;
    end else if (cls3[0]) begin
      res_c = {sign3, {(W-1){1'b0}}};
      flg_c = 4'b0000;
    end else if (!exp_f[EW-1] && (exp_f >= EMAX)) begin
      res_c = SPECIAL ? {sign3, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                      : {sign3, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      flg_c = 4'b0101;
    end else if (exp_f[EW-1] || (exp_f == '0)) begin
      res_c = {sign3, {(W-1){1'b0}}};
      flg_c = 4'b0011;
    end
  end

  logic             v4;
  logic [W-1:0]     data4;
  logic [3:0]       flags4;
  logic [TAG_W-1:0] tag4;

  assign en4      = !v4 || out_ready;
  assign en3      = !v3 || en4;
  assign en2      = !v2 || en3;
  assign en1      = !v1 || en2;
  assign in_ready = en1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      v4     <= 1'b0;
      data4  <= '0;
      flags4 <= '0;
      tag4   <= '0;
    end else begin
      if (en1) begin
        v1    <= in_valid;
        sign1 <= data1[W-1] ^ data2[W-1];
        cls1  <= cls_c;
        exp1  <= {2'b00, ea} + {2'b00, eb} - BIAS;
        prod1 <= sig_a * sig_b;
        tag1  <= in_tag;
      end
      if (en2) begin
        v2      <= v1;
        sign2   <= sign1;
        cls2    <= cls1;
        exp2    <= exp_n;
        kept2   <= kept_c;
        guard2  <= guard_c;
        sticky2 <= sticky_c;
        tag2    <= tag1;
      end
      if (en3) begin
        v3       <= v2;
        sign3    <= sign2;
        cls3     <= cls2;
        exp3     <= exp2;
        sum3     <= sum_c;
        inexact3 <= guard2 | sticky2;
        tag3     <= tag2;
      end
      if (en4) begin
        v4     <= v3;
        data4  <= res_c;
        flags4 <= flg_c;
        tag4   <= tag3;
      end
    end
  end

  assign out_valid = v4;
  assign datanew   = data4;
  assign out_flags = flags4;
  assign out_tag   = tag4;
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - self-checking bench for fp_mul_pipe (FP16 lane plus a BF16 instance)
// Expectations follow FPMUL_SPECIAL_EN when it is defined for the build.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] data1, data2, datanew;
  logic [3:0]  in_tag, out_tag, out_flags;

  logic        bf_in_valid, bf_in_ready, bf_out_valid, bf_out_ready;
  logic [15:0] bf_data1, bf_data2, bf_datanew;
  logic [3:0]  bf_in_tag, bf_out_tag, bf_out_flags;

  fp_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .datanew(datanew),
    .out_tag(out_tag), .out_flags(out_flags)
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(7), .TAG_W(4)) dut_bf (
    .clk(clk), .rst(rst), .in_valid(bf_in_valid), .in_ready(bf_in_ready),
    .data1(bf_data1), .data2(bf_data2), .in_tag(bf_in_tag),
    .out_valid(bf_out_valid), .out_ready(bf_out_ready), .datanew(bf_datanew),
    .out_tag(bf_out_tag), .out_flags(bf_out_flags)
  );

  int checks = 0;
  int passed = 0;
  int out_seen = 0;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  f;
    logic [3:0]  t;
  } res_t;
  res_t exp_q[$];

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [3:0]  f;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  // Exact-integer FP16 reference: product of significands, rounded by remainder comparison.
  function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [3:0] f);
    int ea, eb, e, msb, sh;
    longint p, q, rem, half;
    logic s;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    f  = 4'b0000;
    r  = 16'h0000;
`ifdef FPMUL_SPECIAL_EN
    begin
      bit an, bn, ai, bi;
      an = (ea == 31) && (a[9:0] != 0);
      bn = (eb == 31) && (b[9:0] != 0);
      ai = (ea == 31) && (a[9:0] == 0);
      bi = (eb == 31) && (b[9:0] == 0);
      if (an || bn || (ai && eb == 0) || (bi && ea == 0)) begin
        r = 16'h7E00;
        f = (an || bn) ? 4'b0000 : 4'b1000;
        return;
      end
      if (ai || bi) begin
        r = {s, 15'h7C00};
        return;
      end
    end
`endif
    if (ea == 0 || eb == 0) begin
      r = {s, 15'h0000};
      return;
    end
    p = longint'(1024 + int'(a[9:0])) * longint'(1024 + int'(b[9:0]));
    msb = 0;
    for (int i = 0; i < 40; i++) if (p[i]) msb = i;
    sh   = msb - 10;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    e = ea + eb - 15 + (msb - 20);
    if (q == 2048) begin
      q = q >> 1;
      e++;
    end
    if (e >= 31) begin
`ifdef FPMUL_SPECIAL_EN
      r = {s, 15'h7C00};
`else
      r = {s, 15'h7BFF};
`endif
      f = 4'b0101;
      return;
    end
    if (e <= 0) begin
      r = {s, 15'h0000};
      f = 4'b0011;
      return;
    end
    r = {s, 5'(e), 10'(q)};
    f = {3'b000, rem != 0};
  endfunction

  // One handshake cycle: drive at negedge, settle, then score both sides of the edge to come.
  task automatic cycle(input bit v, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] tg, input bit ordy, output bit acc);
    res_t e;
    @(negedge clk);
    in_valid  = v;
    data1     = a;
    data2     = b;
    in_tag    = tg;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (out_valid && out_ready) begin
      out_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got data %h tag %h, want no output", datanew, out_tag);
      end else begin
        e = exp_q.pop_front();
        chk("stream_result", {8'h0, datanew, out_flags, out_tag}, {8'h0, e.r, e.f, e.t});
      end
    end
    if (acc) begin
      ref_mul(a, b, e.r, e.f);
      e.t = tg;
      exp_q.push_back(e);
    end
  endtask

  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tg,
                         output logic [15:0] r, output logic [3:0] fl, output logic [3:0] t,
                         output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    data1     = a;
    data2     = b;
    in_tag    = tg;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r  = datanew;
    fl = out_flags;
    t  = out_tag;
  endtask

  initial begin
    logic [15:0] r;
    logic [3:0]  fl, t;
    int          lat, acc_n, k, guard;
    bit          a_ok;
    logic [15:0] bf_a[3], bf_b[3], bf_r[3];

    rst = 1'b1; in_valid = 1'b0; data1 = '0; data2 = '0; in_tag = '0; out_ready = 1'b1;
    bf_in_valid = 1'b0; bf_data1 = '0; bf_data2 = '0; bf_in_tag = '0; bf_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_datanew", 32'(datanew), 0);
    chk("reset_flags", 32'(out_flags), 0);
    chk("reset_tag", 32'(out_tag), 0);
    chk("reset_in_ready", 32'(in_ready), 1);

    tbl.push_back('{"basic",    16'h3C00, 16'h3E00, 16'h3E00, 4'h0});
    tbl.push_back('{"negative", 16'h4000, 16'hC200, 16'hC600, 4'h0});
    tbl.push_back('{"tie_odd",  16'h3C01, 16'h3E00, 16'h3E02, 4'h1});
    tbl.push_back('{"tie_even", 16'h3C03, 16'h3E00, 16'h3E04, 4'h1});
    tbl.push_back('{"sticky",   16'h3C01, 16'h3C01, 16'h3C02, 4'h1});
`ifdef FPMUL_SPECIAL_EN
    tbl.push_back('{"overflow", 16'h7BFF, 16'h4000, 16'h7C00, 4'h5});
`else
    tbl.push_back('{"overflow", 16'h7BFF, 16'h4000, 16'h7BFF, 4'h5});
`endif
    tbl.push_back('{"underflow", 16'h0400, 16'h3800, 16'h0000, 4'h3});
    tbl.push_back('{"zero_op",   16'h0000, 16'h3C00, 16'h0000, 4'h0});
    tbl.push_back('{"neg_zero",  16'h8000, 16'h3C00, 16'h8000, 4'h0});
    tbl.push_back('{"max_fin",   16'h7BFF, 16'h3C00, 16'h7BFF, 4'h0});
    tbl.push_back('{"min_norm",  16'h0400, 16'h3C00, 16'h0400, 4'h0});
`ifdef FPMUL_SPECIAL_EN
    tbl.push_back('{"inf_x_zero", 16'h7C00, 16'h0000, 16'h7E00, 4'h8});
    tbl.push_back('{"nan_in",     16'h7E00, 16'h3C00, 16'h7E00, 4'h0});
    tbl.push_back('{"neg_inf",    16'hFC00, 16'h4000, 16'hFC00, 4'h0});
`else
    tbl.push_back('{"exp31_finite", 16'h7C00, 16'h3800, 16'h7800, 4'h0});
`endif

    foreach (tbl[i]) begin
      run_one(tbl[i].a, tbl[i].b, 4'(i), r, fl, t, lat);
      chk({tbl[i].name, "_data"}, 32'(r), 32'(tbl[i].r));
      chk({tbl[i].name, "_flags"}, 32'(fl), 32'(tbl[i].f));
      chk({tbl[i].name, "_tag"}, 32'(t), 32'(i));
      chk({tbl[i].name, "_latency"}, 32'(lat), 4);
    end

    // Backpressure: fill with the consumer stalled, then release.
    out_seen = 0;
    acc_n = 0;
    guard = 0;
    while (acc_n < 4 && guard < 20) begin
      cycle(1'b1, tbl[acc_n].a, tbl[acc_n].b, 4'(acc_n), 1'b0, a_ok);
      if (a_ok) acc_n++;
      guard++;
    end
    chk("bp_accepted", 32'(acc_n), 4);
    cycle(1'b1, tbl[4].a, tbl[4].b, 4'd4, 1'b0, a_ok);
    chk("bp_in_ready_low", 32'(a_ok), 0);
    chk("bp_hold_1", {15'h0, out_valid, datanew}, {15'h0, 1'b1, exp_q[0].r});
    cycle(1'b1, tbl[4].a, tbl[4].b, 4'd4, 1'b0, a_ok);
    chk("bp_hold_2", {12'h0, out_tag, datanew}, {12'h0, exp_q[0].t, exp_q[0].r});
    k = 4;
    guard = 0;
    while (k < 8 && guard < 40) begin
      cycle(1'b1, tbl[k].a, tbl[k].b, 4'(k), 1'b1, a_ok);
      if (a_ok) k++;
      guard++;
    end
    repeat (12) cycle(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, a_ok);
    chk("bp_out_count", 32'(out_seen), 8);
    chk("bp_queue_empty", 32'(exp_q.size()), 0);

    // Random traffic with random stalls against the reference model.
    repeat (400)
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 4'($urandom),
            $urandom_range(0, 2) != 0, a_ok);
    repeat (20) cycle(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, a_ok);
    chk("random_queue_empty", 32'(exp_q.size()), 0);

    // Reset with three operations in flight.
    repeat (3) cycle(1'b1, 16'h3C00, 16'h3E00, 4'h9, 1'b1, a_ok);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_datanew", 32'(datanew), 0);
    exp_q.delete();
    out_seen = 0;
    repeat (8) cycle(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, a_ok);
    chk("midrst_no_stale", 32'(out_seen), 0);

    // BF16 instance.
    bf_a[0] = 16'h3FC0; bf_b[0] = 16'h4000; bf_r[0] = 16'h4040;
    bf_a[1] = 16'h3F80; bf_b[1] = 16'h3F80; bf_r[1] = 16'h3F80;
    bf_a[2] = 16'hC000; bf_b[2] = 16'h3FC0; bf_r[2] = 16'hC040;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bf_in_valid = 1'b1;
      bf_data1 = bf_a[i];
      bf_data2 = bf_b[i];
      bf_in_tag = 4'(i + 3);
      @(posedge clk);
      @(negedge clk);
      bf_in_valid = 1'b0;
      lat = 1;
      while (!bf_out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("bf16_data", 32'(bf_datanew), 32'(bf_r[i]));
      chk("bf16_flags_tag", {24'h0, bf_out_flags, bf_out_tag}, 32'(i + 3));
      chk("bf16_latency", 32'(lat), 4);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
